qar_imem_prefetch: RTL and testbench

Instruction prefetch buffer between the qar_core instruction port (imem_valid/imem_addr/imem_ready/imem_rdata) and a pipelined, variable-latency instruction memory. It streams sequential words ahead of the core into a small FIFO. It answers in-order fetches in the same cycle from the FIFO head, and redirects the stream on any non-sequential fetch (branch, trap, reset vector).

---
 rtl/qar_pkg.sv | 15 +
 rtl/qar_sync_fifo.sv | 55 +++++
 rtl/qar_imem_prefetch.sv | 133 +++++++++++++
 tb/tb_qar_imem_prefetch.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/qar_pkg.sv
// qar_pkg: shared constants and types for the qar instruction fetch path.
//   QAR_XLEN     address width
//   QAR_ILEN     instruction word width
//   QAR_PC_ALIGN byte alignment of an instruction word
//   qar_pf_state_e  prefetch controller state
package qar_pkg;
  localparam int QAR_XLEN     = 32;
  localparam int QAR_ILEN     = 32;
  localparam int QAR_PC_ALIGN = 4;

  typedef enum logic {
    PF_IDLE = 1'b0,
    PF_RUN  = 1'b1
  } qar_pf_state_e;
endpackage

// File: rtl/qar_sync_fifo.sv
// qar_sync_fifo: single-clock FIFO with synchronous flush.
//   clk_i, rst_ni      clock, synchronous active-low reset
//   push_i, wdata_i    write request and data (ignored when full unless popping)
//   pop_i              read request (ignored when empty)
//   flush_i            empty the FIFO; wins over push in the same cycle
//   rdata_o            head entry (meaningful only when !empty_o)
//   full_o, empty_o, count_o  occupancy status
module qar_sync_fifo
  import qar_pkg::*;
#(
  parameter int WIDTH = QAR_ILEN,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  input  logic             flush_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  // A full FIFO may still accept a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/qar_imem_prefetch.sv
// qar_imem_prefetch: sequential instruction prefetcher between the core fetch
// port and a pipelined, in-order, variable-latency instruction memory.
//   clk_i, rst_ni                      clock, synchronous active-low reset
//   imem_valid_i, imem_addr_i          core fetch request (held until ready)
//   imem_ready_o, imem_rdata_o         same-cycle answer from the FIFO head
//   mem_req_o, mem_addr_o, mem_gnt_i   memory request handshake
//   mem_rvalid_i, mem_rdata_i          in-order memory response
//   hit_count_o, miss_count_o          saturating statistics, present only
//                                      when QAR_PREFETCH_STATS_EN is defined
module qar_imem_prefetch
  import qar_pkg::*;
#(
  parameter int                  DEPTH    = 4,
  parameter logic [QAR_XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                imem_valid_i,
  input  logic [QAR_XLEN-1:0] imem_addr_i,
  output logic                imem_ready_o,
  output logic [QAR_ILEN-1:0] imem_rdata_o,
  output logic                mem_req_o,
  output logic [QAR_XLEN-1:0] mem_addr_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [QAR_ILEN-1:0] mem_rdata_i
`ifdef QAR_PREFETCH_STATS_EN
  ,
  output logic [31:0]         hit_count_o,
  output logic [31:0]         miss_count_o
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [QAR_XLEN-1:0] STEP = QAR_XLEN'(QAR_PC_ALIGN);

  qar_pf_state_e       state_q;
  logic [QAR_XLEN-1:0] fetch_ptr_q, fetch_ptr_d;
  logic [QAR_XLEN-1:0] exp_addr_q, exp_addr_d;
  logic [CW-1:0]       out_cnt_q, out_cnt_d;
  logic [CW-1:0]       drop_cnt_q, drop_cnt_d;

  logic [QAR_XLEN-1:0] req_addr;
  logic [CW-1:0]       fifo_cnt;
  logic [CW:0]         inflight;
  logic [QAR_ILEN-1:0] fifo_head;
  logic                fifo_full, fifo_empty;
  logic                hit, miss, grant, rsp, push;

  assign req_addr = imem_addr_i & ~(STEP - 1'b1);

  // The FIFO only holds data: the head always belongs to exp_addr_q, and each
  // later entry to the next sequential word.
  assign hit  = imem_valid_i && !fifo_empty && (req_addr == exp_addr_q);
  assign miss = imem_valid_i && (req_addr != exp_addr_q);

  // Occupancy plus every in-flight grant (including ones to be dropped) is
  // capped at DEPTH, so a response always has a free slot.
  assign inflight  = {1'b0, fifo_cnt} + {1'b0, out_cnt_q};
  assign mem_req_o = (state_q == PF_RUN) && !fifo_full && (inflight < (CW+1)'(DEPTH));
  assign mem_addr_o = fetch_ptr_q;

  assign grant = mem_req_o && mem_gnt_i;
  assign rsp   = mem_rvalid_i && (out_cnt_q != '0);
  assign push  = rsp && (drop_cnt_q == '0) && !miss;

  assign imem_ready_o = hit;
  assign imem_rdata_o = hit ? fifo_head : '0;

  always_comb begin
    out_cnt_d   = out_cnt_q + CW'(grant) - CW'(rsp);
    drop_cnt_d  = drop_cnt_q;
    fetch_ptr_d = fetch_ptr_q;
    exp_addr_d  = exp_addr_q;
    if (grant) fetch_ptr_d = fetch_ptr_q + STEP;
    if (hit)   exp_addr_d  = exp_addr_q + STEP;
    if (miss) begin
      // Everything still owed by memory after this cycle belongs to the old stream.
      drop_cnt_d  = out_cnt_d;
      fetch_ptr_d = req_addr;
      exp_addr_d  = req_addr;
    end else if (rsp && drop_cnt_q != '0) begin
      drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= PF_IDLE;
      fetch_ptr_q <= RESET_PC;
      exp_addr_q  <= RESET_PC;
      out_cnt_q   <= '0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= PF_RUN;
      fetch_ptr_q <= fetch_ptr_d;
      exp_addr_q  <= exp_addr_d;
      out_cnt_q   <= out_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  qar_sync_fifo #(.WIDTH(QAR_ILEN), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .wdata_i (mem_rdata_i),
    .pop_i   (hit),
    .flush_i (miss),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

`ifdef QAR_PREFETCH_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit  && hit_cnt_q  != '1) hit_cnt_q  <= hit_cnt_q  + 1'b1;
      if (miss && miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end
  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;
`endif

  // A response with nothing outstanding means the memory broke the protocol.
  a_rsp_without_req : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(mem_rvalid_i && out_cnt_q == '0));
endmodule

// File: tb/tb_qar_imem_prefetch.sv
// tb_qar_imem_prefetch: directed bench for qar_imem_prefetch (DEPTH=4,
// RESET_PC=0). Memory word for address a is {16'hC0DE, a[15:0]}.
// Honors QAR_PREFETCH_STATS_EN for the optional counter ports.
module tb_qar_imem_prefetch;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_valid;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
`ifdef QAR_PREFETCH_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  qar_imem_prefetch #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .imem_valid_i(imem_valid), .imem_addr_i(imem_addr),
    .imem_ready_o(imem_ready), .imem_rdata_o(imem_rdata),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
`ifdef QAR_PREFETCH_STATS_EN
    , .hit_count_o(hit_count), .miss_count_o(miss_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  function automatic logic [31:0] W(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- per-cycle vector table ----------------
  typedef struct {
    logic        iv;   logic [31:0] ia;
    logic        gnt;  logic        rv;   logic [31:0] rd;
    logic        er;   logic [31:0] erd;
    logic        ereq; logic [31:0] ema;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] ia, input logic rv, input logic [31:0] rd,
                              input logic er, input logic [31:0] erd,
                              input logic ereq, input logic [31:0] ema);
    vec_t v;
    v.iv = 1'b1; v.ia = ia; v.gnt = 1'b1; v.rv = rv; v.rd = rd;
    v.er = er; v.erd = erd; v.ereq = ereq; v.ema = ema;
    return v;
  endfunction

  // ---------------- memory / core model for longer sequences ----------------
  typedef struct { int due; logic [31:0] data; } rsp_t;
  rsp_t        rsp_q[$];
  int          cyc, lat;
  bit          gnt_toggle, gnt_phase, core_en;
  logic [31:0] core_pc;
  int          n_del, n_rcv, max_level;
  logic        s_req, s_ready;

  task automatic mcycle();
    mem_gnt = gnt_toggle ? gnt_phase : 1'b1;
    gnt_phase = ~gnt_phase;
    if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      mem_rvalid = 1'b1; mem_rdata = rsp_q[0].data;
    end else begin
      mem_rvalid = 1'b0; mem_rdata = '0;
    end
    imem_valid = core_en;
    imem_addr  = core_pc;
    @(negedge clk);
    s_req = mem_req; s_ready = imem_ready;
    if (mem_rvalid) begin void'(rsp_q.pop_front()); n_rcv++; end
    if (mem_req && mem_gnt) rsp_q.push_back('{cyc + lat, W(mem_addr)});
    if (imem_ready) begin
      check("deliver_data", imem_rdata, W(core_pc));
      core_pc += 4; n_del++;
    end
    if (rsp_q.size() + (n_rcv - n_del) > max_level) max_level = rsp_q.size() + (n_rcv - n_del);
    @(posedge clk); #1; cyc++;
  endtask

  task automatic do_reset(input int l, input bit tog);
    rst_n = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; imem_valid = 1'b0;
    rsp_q.delete();
    lat = l; gnt_toggle = tog; gnt_phase = 1'b1; core_en = 1'b1; core_pc = 32'h0;
    n_del = 0; n_rcv = 0; max_level = 0;
    @(posedge clk); #1; cyc++;
    rst_n = 1'b1;
  endtask

  task automatic run_until(input string name, input int words, input int budget);
    int b = budget;
    while (n_del < words && b > 0) begin mcycle(); b--; end
    check(name, n_del, words);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t tv[13];
    tv[0]  = mk(32'h00, 0, 32'h0,     0, 32'h0,     0, 32'h00);
    tv[1]  = mk(32'h00, 0, 32'h0,     0, 32'h0,     1, 32'h00);
    tv[2]  = mk(32'h00, 1, W(32'h00), 0, 32'h0,     1, 32'h04);
    tv[3]  = mk(32'h00, 1, W(32'h04), 1, W(32'h00), 1, 32'h08);
    tv[4]  = mk(32'h04, 1, W(32'h08), 1, W(32'h04), 1, 32'h0C);
    tv[5]  = mk(32'h08, 1, W(32'h0C), 1, W(32'h08), 1, 32'h10);
    tv[6]  = mk(32'h0C, 1, W(32'h10), 1, W(32'h0C), 1, 32'h14);
    tv[7]  = mk(32'h40, 1, W(32'h14), 0, 32'h0,     1, 32'h18); // miss: 0x14 word discarded
    tv[8]  = mk(32'h40, 1, W(32'h18), 0, 32'h0,     1, 32'h40); // stale 0x18 dropped
    tv[9]  = mk(32'h40, 1, W(32'h40), 0, 32'h0,     1, 32'h44);
    tv[10] = mk(32'h40, 1, W(32'h44), 1, W(32'h40), 1, 32'h48); // t0+3
    tv[11] = mk(32'h44, 1, W(32'h48), 1, W(32'h44), 1, 32'h4C);
    tv[12] = mk(32'h48, 1, W(32'h4C), 1, W(32'h48), 1, 32'h50);

    // Reset state
    rst_n = 1'b0; imem_valid = 1'b0; imem_addr = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    cyc = 0; lat = 1; gnt_toggle = 0; gnt_phase = 1; core_en = 0; core_pc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_mem_req", mem_req, 0);
    check("reset_mem_addr", mem_addr, 32'h0);
    check("reset_imem_ready", imem_ready, 0);
    check("reset_imem_rdata", imem_rdata, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Startup stream, then redirect to 0x40
    for (int i = 0; i < 13; i++) begin
      imem_valid = tv[i].iv; imem_addr = tv[i].ia;
      mem_gnt = tv[i].gnt; mem_rvalid = tv[i].rv; mem_rdata = tv[i].rd;
      @(negedge clk);
      check($sformatf("vec%0d_mem_req", i), mem_req, tv[i].ereq);
      if (tv[i].ereq) check($sformatf("vec%0d_mem_addr", i), mem_addr, tv[i].ema);
      check($sformatf("vec%0d_imem_ready", i), imem_ready, tv[i].er);
      if (tv[i].er) check($sformatf("vec%0d_imem_rdata", i), imem_rdata, tv[i].erd);
`ifdef QAR_PREFETCH_STATS_EN
      if (i == 12) begin
        check("stats_hit_count", hit_count, 32'd6);
        check("stats_miss_count", miss_count, 32'd1);
      end
`endif
      @(posedge clk); #1;
    end

    // One-cycle reset mid-stream (FIFO holds 0x4C word, 0x50 in flight)
    rst_n = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    imem_valid = 1'b1; imem_addr = 32'h0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_mem_req", mem_req, 0);
    check("rst_mid_imem_ready", imem_ready, 0);
    check("rst_mid_mem_addr", mem_addr, 32'h0);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_restart_mem_req", mem_req, 1);
    check("rst_restart_mem_addr", mem_addr, 32'h0);
    check("rst_restart_imem_ready", imem_ready, 0);
    @(posedge clk); #1;

    // L=3, grant toggling: ordered delivery, in-flight + buffered never above DEPTH
    do_reset(3, 1'b1);
    run_until("lat3_words", 16, 400);
    check("lat3_level_le_depth", 32'(max_level <= DEPTH), 32'd1);

    // Core stall: FIFO fills, requests stop, then four back-to-back hits
    do_reset(1, 1'b0);
    run_until("stall_prefix_words", 3, 50);
    core_en = 1'b0;
    repeat (10) mcycle();
    check("stall_mem_req", s_req, 0);
    core_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mcycle();
      check($sformatf("resume_hit%0d", k), s_ready, 1);
    end

    // Two redirects two cycles apart with L=4: only the 0x200 stream appears
    do_reset(4, 1'b0);
    run_until("dmiss_prefix_words", 2, 60);
    core_pc = 32'h80;
    mcycle(); mcycle();
    core_pc = 32'h200;
    n_del = 0;
    run_until("dmiss_words", 6, 200);
    check("dmiss_final_pc", core_pc, 32'h218);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
